// File: rtl/micro_sequencer_alu.sv
// micro_sequencer_alu
//   Hardwired control sequencer for instruction fetch and ALU reg/imm execution.
//   Drives the datapath bus-drive and load strobes each cycle from a Moore FSM.
//   Fetch waits on MemReady with a timeout. The block supports run/stop control,
//   an illegal-opcode trap and HALT.
// Ports
//   Clock, Clear (async, active-low)       clock / reset
//   Run, StopReq, MemReady                 control level, stop pulse, memory data valid
//   IR[DATA_W-1:0]                         instruction register (opcode in top OPC_W bits)
//   PCout Zlowout MDRout Rout Cout         bus-drive strobes
//   MARin Zin PCin MDRin IRin Yin Rin      load strobes
//   IncPC Read Gra Grb Grc                 PC increment, memory read, register selects
//   AluOp[3:0]                             one-hot {OR,AND,SUB,ADD}, 0 = pass-through
//   Busy                                   1 outside IDLE/HALT/TRAP
//   Trap[1:0]                              sticky cause: 01 illegal opcode, 10 memory timeout
module micro_sequencer_alu #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned OPC_W       = 5,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              Run,
  input  logic              StopReq,
  input  logic              MemReady,
  input  logic [DATA_W-1:0] IR,
  output logic              PCout,
  output logic              Zlowout,
  output logic              MDRout,
  output logic              Rout,
  output logic              Cout,
  output logic              MARin,
  output logic              Zin,
  output logic              PCin,
  output logic              MDRin,
  output logic              IRin,
  output logic              Yin,
  output logic              Rin,
  output logic              IncPC,
  output logic              Read,
  output logic              Gra,
  output logic              Grb,
  output logic              Grc,
  output logic [3:0]        AluOp,
  output logic              Busy,
  output logic [1:0]        Trap
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT, S_TRAP
  } state_t;

  typedef struct packed {
    logic       pc_out, zlow_out, mdr_out, r_out, c_out;
    logic       mar_in, z_in, pc_in, mdr_in, ir_in, y_in, r_in;
    logic       inc_pc, read, gra, grb, grc;
    logic [3:0] alu_op;
    logic       busy;
  } ctl_t;

  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(5'b00011);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(5'b00100);
  localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(5'b00101);
  localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(5'b00110);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5'b01001);
  localparam logic [OPC_W-1:0] OP_ANDI = OPC_W'(5'b01010);
  localparam logic [OPC_W-1:0] OP_ORI  = OPC_W'(5'b01011);
  localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(5'b11011);

  // T1 occupies exactly MEM_TIMEOUT cycles without MemReady before trapping.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, next;
  ctl_t       ctl, ctl_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic       stop_flag, stop_nxt;
  logic       halt_armed, armed_nxt;
  logic [1:0] trap_q, trap_nxt;

  logic [OPC_W-1:0] op;
  logic             op_rtype, op_itype;
  logic [3:0]       op_alu;
  logic             unused_ir;

  assign op        = IR[DATA_W-1 -: OPC_W];
  assign unused_ir = ^IR[DATA_W-OPC_W-1:0];

  always_comb begin
    op_rtype = 1'b0;
    op_itype = 1'b0;
    op_alu   = '0;
    case (op)
      OP_ADD:  begin op_rtype = 1'b1; op_alu = 4'b0001; end
      OP_SUB:  begin op_rtype = 1'b1; op_alu = 4'b0010; end
      OP_AND:  begin op_rtype = 1'b1; op_alu = 4'b0100; end
      OP_OR:   begin op_rtype = 1'b1; op_alu = 4'b1000; end
      OP_ADDI: begin op_itype = 1'b1; op_alu = 4'b0001; end
      OP_ANDI: begin op_itype = 1'b1; op_alu = 4'b0100; end
      OP_ORI:  begin op_itype = 1'b1; op_alu = 4'b1000; end
      default: ;
    endcase
  end

  always_comb begin
    next      = state;
    ctl_nxt   = '0;
    wait_nxt  = wait_cnt;
    stop_nxt  = stop_flag;
    armed_nxt = halt_armed;
    trap_nxt  = trap_q;

    if (StopReq && state != S_IDLE) stop_nxt = 1'b1;

    case (state)
      S_IDLE: if (Run) next = S_T0;
      S_T0:   next = S_T1;
      S_T1: begin
        if (MemReady) begin
          next = S_T2;
        end else if (wait_cnt == TIMEOUT_LAST) begin
          next     = S_TRAP;
          trap_nxt = 2'b10;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end
      S_T2:   next = S_T3;
      S_T3: begin
        if (op_rtype || op_itype) begin
          next = S_T4;
        end else if (op == OP_HALT) begin
          next = S_HALT;
        end else begin
          next     = S_TRAP;
          trap_nxt = 2'b01;
        end
      end
      S_T4:   next = S_T5;
      S_T5:   next = (stop_flag || StopReq || !Run) ? S_IDLE : S_T0;
      S_HALT: begin
        // Resume needs Run seen low while halted, then high again.
        if (!Run)            armed_nxt = 1'b1;
        else if (halt_armed) next      = S_T0;
      end
      S_TRAP: ;
      default: next = S_IDLE;
    endcase

    if (next == S_T1 && state != S_T1)     wait_nxt  = '0;
    if (next == S_IDLE)                    stop_nxt  = 1'b0;
    if (next == S_HALT && state != S_HALT) armed_nxt = 1'b0;

    // Outputs are the registered decode of the next state.
    case (next)
      S_T0: begin
        ctl_nxt.pc_out = 1'b1; ctl_nxt.mar_in = 1'b1;
        ctl_nxt.inc_pc = 1'b1; ctl_nxt.z_in   = 1'b1;
        ctl_nxt.busy   = 1'b1;
      end
      S_T1: begin
        ctl_nxt.read   = 1'b1; ctl_nxt.mdr_in = 1'b1;
        ctl_nxt.busy   = 1'b1;
        if (state != S_T1) begin
          ctl_nxt.zlow_out = 1'b1; ctl_nxt.pc_in = 1'b1;
        end
      end
      S_T2: begin
        ctl_nxt.mdr_out = 1'b1; ctl_nxt.ir_in = 1'b1;
        ctl_nxt.busy    = 1'b1;
      end
      S_T3: begin
        ctl_nxt.grb  = 1'b1; ctl_nxt.r_out = 1'b1;
        ctl_nxt.y_in = 1'b1; ctl_nxt.busy  = 1'b1;
      end
      S_T4: begin
        if (op_rtype) begin
          ctl_nxt.grc = 1'b1; ctl_nxt.r_out = 1'b1;
        end else begin
          ctl_nxt.c_out = 1'b1;
        end
        ctl_nxt.alu_op = op_alu;
        ctl_nxt.z_in   = 1'b1;
        ctl_nxt.busy   = 1'b1;
      end
      S_T5: begin
        ctl_nxt.zlow_out = 1'b1; ctl_nxt.gra = 1'b1;
        ctl_nxt.r_in     = 1'b1; ctl_nxt.busy = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state      <= S_IDLE;
      ctl        <= '0;
      wait_cnt   <= '0;
      stop_flag  <= 1'b0;
      halt_armed <= 1'b0;
      trap_q     <= '0;
    end else begin
      state      <= next;
      ctl        <= ctl_nxt;
      wait_cnt   <= wait_nxt;
      stop_flag  <= stop_nxt;
      halt_armed <= armed_nxt;
      trap_q     <= trap_nxt;
    end
  end

  assign PCout   = ctl.pc_out;
  assign Zlowout = ctl.zlow_out;
  assign MDRout  = ctl.mdr_out;
  assign Rout    = ctl.r_out;
  assign Cout    = ctl.c_out;
  assign MARin   = ctl.mar_in;
  assign Zin     = ctl.z_in;
  assign PCin    = ctl.pc_in;
  assign MDRin   = ctl.mdr_in;
  assign IRin    = ctl.ir_in;
  assign Yin     = ctl.y_in;
  assign Rin     = ctl.r_in;
  assign IncPC   = ctl.inc_pc;
  assign Read    = ctl.read;
  assign Gra     = ctl.gra;
  assign Grb     = ctl.grb;
  assign Grc     = ctl.grc;
  assign AluOp   = ctl.alu_op;
  assign Busy    = ctl.busy;
  assign Trap    = trap_q;

endmodule

// File: tb/tb_micro_sequencer_alu.sv
module tb_micro_sequencer_alu;

  logic        Clock = 1'b0;
  logic        Clear, Run, StopReq, MemReady;
  logic [31:0] IR;
  logic PCout, Zlowout, MDRout, Rout, Cout, MARin, Zin, PCin, MDRin, IRin, Yin, Rin;
  logic IncPC, Read, Gra, Grb, Grc, Busy;
  logic [3:0] AluOp;
  logic [1:0] Trap;

  micro_sequencer_alu #(.DATA_W(32), .OPC_W(5), .MEM_TIMEOUT(15)) dut (
    .Clock(Clock), .Clear(Clear), .Run(Run), .StopReq(StopReq), .MemReady(MemReady), .IR(IR),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Rout(Rout), .Cout(Cout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Rin(Rin),
    .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .AluOp(AluOp), .Busy(Busy), .Trap(Trap)
  );

  always #5 Clock = ~Clock;

  // Observed word: {Busy, Trap[1:0], AluOp[3:0], 17 strobes}
  localparam int S_GRC = 0, S_GRB = 1, S_GRA = 2, S_READ = 3, S_INCPC = 4, S_RIN = 5;
  localparam int S_YIN = 6, S_IRIN = 7, S_MDRIN = 8, S_PCIN = 9, S_ZIN = 10, S_MARIN = 11;
  localparam int S_COUT = 12, S_ROUT = 13, S_MDROUT = 14, S_ZLOWOUT = 15, S_PCOUT = 16;
  localparam logic [23:0] BUSY = 24'd1 << 23;
  localparam logic [23:0] E_IDLE = 24'd0;
  localparam logic [23:0] E_T0  = BUSY | (24'd1 << S_PCOUT) | (24'd1 << S_MARIN) |
                                  (24'd1 << S_INCPC) | (24'd1 << S_ZIN);
  localparam logic [23:0] E_T1F = BUSY | (24'd1 << S_ZLOWOUT) | (24'd1 << S_PCIN) |
                                  (24'd1 << S_READ) | (24'd1 << S_MDRIN);
  localparam logic [23:0] E_T1H = BUSY | (24'd1 << S_READ) | (24'd1 << S_MDRIN);
  localparam logic [23:0] E_T2  = BUSY | (24'd1 << S_MDROUT) | (24'd1 << S_IRIN);
  localparam logic [23:0] E_T3  = BUSY | (24'd1 << S_GRB) | (24'd1 << S_ROUT) | (24'd1 << S_YIN);
  localparam logic [23:0] E_T5  = BUSY | (24'd1 << S_ZLOWOUT) | (24'd1 << S_GRA) | (24'd1 << S_RIN);
  localparam logic [23:0] E_TRAP_ILL = 24'd1 << 21;
  localparam logic [23:0] E_TRAP_MEM = 24'd1 << 22;

  logic [23:0] obs;
  assign obs = {Busy, Trap, AluOp, PCout, Zlowout, MDRout, Rout, Cout, MARin, Zin, PCin,
                MDRin, IRin, Yin, Rin, IncPC, Read, Gra, Grb, Grc};

  int errors = 0;
  int checks = 0;
  int step   = 0;
  logic [23:0] sb[$];

  function automatic logic [23:0] t4(input logic rtype, input logic [3:0] alu);
    logic [23:0] w;
    w = BUSY | (24'd1 << S_ZIN) | {3'b000, alu, 17'd0};
    if (rtype) w = w | (24'd1 << S_GRC) | (24'd1 << S_ROUT);
    else       w = w | (24'd1 << S_COUT);
    return w;
  endfunction

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %06h expected %06h", name, got, exp);
    end
  endtask

  // Scoreboard: expected word for the state entered at a posedge is compared mid-cycle.
  always @(negedge Clock) begin
    if (sb.size() != 0) begin
      step++;
      check($sformatf("cyc%0d", step), obs, sb.pop_front());
    end
  end

  task automatic cyc(input logic [23:0] exp);
    @(posedge Clock);
    sb.push_back(exp);
    #1;
  endtask

  // One instruction from the edge entering T0 through the edge entering T5.
  task automatic do_instr(input logic [31:0] ir, input int delay, input logic stop,
                          input logic [23:0] exp_t4);
    IR = ir;
    Run = 1'b1;
    MemReady = 1'b0;
    cyc(E_T0);
    cyc(E_T1F);
    for (int i = 0; i < delay; i++) begin
      MemReady = 1'b0;
      cyc(E_T1H);
    end
    MemReady = 1'b1;
    cyc(E_T2);
    MemReady = 1'b0;
    StopReq = stop;
    cyc(E_T3);
    StopReq = 1'b0;
    cyc(exp_t4);
    cyc(E_T5);
  endtask

  task automatic do_reset();
    @(negedge Clock);
    #1;
    Clear = 1'b0;
    #1;
    check("async_clear", obs, E_IDLE);
    Run = 1'b0; StopReq = 1'b0; MemReady = 1'b0;
    @(posedge Clock);
    #2;
    Clear = 1'b1;
    cyc(E_IDLE);
  endtask

  typedef struct {
    logic [31:0] ir;
    int          delay;
    logic        stop;
    logic        run_off;
    logic [23:0] exp_t4;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{32'h59080023, 0, 1'b0, 1'b0, t4(1'b0, 4'b1000)}; // ori
    vecs[1] = '{32'h18000000, 0, 1'b0, 1'b0, t4(1'b1, 4'b0001)}; // add
    vecs[2] = '{32'h20000000, 3, 1'b1, 1'b0, t4(1'b1, 4'b0010)}; // sub, slow mem, stop
    vecs[3] = '{32'h28000000, 1, 1'b0, 1'b1, t4(1'b1, 4'b0100)}; // and, Run dropped
    vecs[4] = '{32'h30000000, 0, 1'b0, 1'b0, t4(1'b1, 4'b1000)}; // or
    vecs[5] = '{32'h48000000, 2, 1'b0, 1'b0, t4(1'b0, 4'b0001)}; // addi
    vecs[6] = '{32'h50000000, 0, 1'b1, 1'b0, t4(1'b0, 4'b0100)}; // andi, stop

    Clear = 1'b0; Run = 1'b0; StopReq = 1'b0; MemReady = 1'b0; IR = '0;
    #3;
    check("reset_state", obs, E_IDLE);
    #9;
    Clear = 1'b1;
    cyc(E_IDLE);

    foreach (vecs[k]) begin
      do_instr(vecs[k].ir, vecs[k].delay, vecs[k].stop, vecs[k].exp_t4);
      if (vecs[k].stop || vecs[k].run_off) begin
        if (vecs[k].run_off) Run = 1'b0;
        cyc(E_IDLE);
        Run = 1'b1;
      end
    end

    // StopReq while idle must not end the next instruction early.
    Run = 1'b0; StopReq = 1'b1;
    cyc(E_IDLE);
    StopReq = 1'b0;
    cyc(E_IDLE);
    do_instr(32'h59080023, 0, 1'b0, t4(1'b0, 4'b1000));
    cyc(E_T0);
    // Continue into add, then Clear during T4.
    MemReady = 1'b0; IR = 32'h18000000;
    cyc(E_T1F);
    MemReady = 1'b1;
    cyc(E_T2);
    MemReady = 1'b0;
    cyc(E_T3);
    cyc(t4(1'b1, 4'b0001));
    do_reset();

    // Illegal opcode traps and holds until Clear.
    Run = 1'b1; IR = 32'hF8000000;
    cyc(E_T0);
    cyc(E_T1F);
    MemReady = 1'b1;
    cyc(E_T2);
    MemReady = 1'b0;
    cyc(E_T3);
    cyc(E_TRAP_ILL);
    MemReady = 1'b1;
    cyc(E_TRAP_ILL);
    cyc(E_TRAP_ILL);
    MemReady = 1'b0;
    do_reset();

    // HALT: stays while Run high, resumes only on 0->1 of Run.
    Run = 1'b1; IR = 32'hD8000000;
    cyc(E_T0);
    cyc(E_T1F);
    MemReady = 1'b1;
    cyc(E_T2);
    MemReady = 1'b0;
    cyc(E_T3);
    cyc(E_IDLE);
    cyc(E_IDLE);
    Run = 1'b0;
    cyc(E_IDLE);
    cyc(E_IDLE);
    Run = 1'b1;
    cyc(E_T0);
    cyc(E_T1F);
    do_reset();

    // Memory timeout: MEM_TIMEOUT cycles in T1 with no MemReady.
    Run = 1'b1; IR = 32'h18000000; MemReady = 1'b0;
    cyc(E_T0);
    cyc(E_T1F);
    for (int i = 0; i < 14; i++) cyc(E_T1H);
    cyc(E_TRAP_MEM);
    cyc(E_TRAP_MEM);
    do_reset();

    // Timeout bound hit together with MemReady: fetch proceeds.
    Run = 1'b1; IR = 32'h18000000; MemReady = 1'b0;
    cyc(E_T0);
    cyc(E_T1F);
    for (int i = 0; i < 14; i++) cyc(E_T1H);
    MemReady = 1'b1;
    cyc(E_T2);
    MemReady = 1'b0;
    cyc(E_T3);

    @(negedge Clock);
    #1;
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
